// File: rtl/mcu_exec_core.sv
// mcu_exec_core: execution core of the 8-bit, 4-stage microcontroller.
// Holds the combinational control decoder, the 8-bit ALU with its operand-2
// select, and a 16x8 data memory.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset (clears dmem)
//   stage[1:0]                    00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE
//   ir[11:0], sr[3:0]             instruction register, flags {Z,C,S,O}
//   acc[7:0], dr[7:0]             ALU operand 1, data register (M-type operand 2)
//   alu_out[7:0]                  ALU result, also data-memory write data
//   sr_new[3:0]                   next flags
//   dmem_rdata[7:0]               data-memory read data
//   pc_e..pmem_le, mux1_sel       register/program-memory enables, PC source
//
// Optional feature macro: ALU_ROTATE_EN. When it is defined, ALU modes A/B
// rotate operand 2. When it is undefined, those modes pass operand 2
// through unchanged.
module mcu_exec_core #(
    parameter int DMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stage,
    input  logic [11:0] ir,
    input  logic [3:0]  sr,
    input  logic [7:0]  acc,
    input  logic [7:0]  dr,
    output logic [7:0]  alu_out,
    output logic [3:0]  sr_new,
    output logic [7:0]  dmem_rdata,
    output logic        pc_e,
    output logic        acc_e,
    output logic        sr_e,
    output logic        ir_e,
    output logic        dr_e,
    output logic        pmem_e,
    output logic        pmem_le,
    output logic        mux1_sel
);

    localparam logic [1:0] ST_LOAD    = 2'b00;
    localparam logic [1:0] ST_FETCH   = 2'b01;
    localparam logic [1:0] ST_DECODE  = 2'b10;
    localparam logic [1:0] ST_EXECUTE = 2'b11;

    logic       alu_e_s;
    logic       mux2_sel_s;
    logic       dmem_e_s;
    logic       dmem_we_s;
    logic [3:0] alu_mode_s;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic [2:0] sh_s;
    logic [7:0] asr_s;
    logic [8:0] r9_s;
    logic       o_s;
    logic [3:0] addr_s;
    logic       in_range_s;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];

`ifdef ALU_ROTATE_EN
    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
        return (v << s) | (v >> (4'd8 - {1'b0, s}));
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
        return (v >> s) | (v << (4'd8 - {1'b0, s}));
    endfunction
`endif

    // Control decoder: stage/IR/flags to enables, ALU mode and PC source.
    always_comb begin
        pc_e       = 1'b0;
        acc_e      = 1'b0;
        sr_e       = 1'b0;
        ir_e       = 1'b0;
        dr_e       = 1'b0;
        pmem_e     = 1'b0;
        pmem_le    = 1'b0;
        mux1_sel   = 1'b0;
        mux2_sel_s = 1'b0;
        alu_e_s    = 1'b0;
        dmem_e_s   = 1'b0;
        dmem_we_s  = 1'b0;
        alu_mode_s = 4'h0;
        case (stage)
            ST_LOAD: begin
                pmem_le = 1'b1;
                pmem_e  = 1'b1;
            end
            ST_FETCH: begin
                ir_e   = 1'b1;
                pmem_e = 1'b1;
            end
            ST_DECODE: begin
                // M-type instructions prefetch their operand into DR.
                if (ir[11:9] == 3'b001) begin
                    dr_e     = 1'b1;
                    dmem_e_s = 1'b1;
                end else begin
                    dr_e = 1'b0;
                end
            end
            ST_EXECUTE: begin
                if (ir[11]) begin
                    pc_e       = 1'b1;
                    acc_e      = 1'b1;
                    sr_e       = 1'b1;
                    alu_e_s    = 1'b1;
                    alu_mode_s = {1'b0, ir[10:8]};
                    mux1_sel   = 1'b1;
                end else if (ir[10]) begin
                    // Jump taken (PC <- ir[7:0]) when the selected flag is set.
                    pc_e     = 1'b1;
                    mux1_sel = ~sr[ir[9:8]];
                end else if (ir[9]) begin
                    pc_e       = 1'b1;
                    sr_e       = 1'b1;
                    alu_e_s    = 1'b1;
                    alu_mode_s = ir[7:4];
                    mux2_sel_s = 1'b1;
                    mux1_sel   = 1'b1;
                    // ir[8] picks the destination: accumulator or data memory.
                    if (ir[8]) begin
                        acc_e = 1'b1;
                    end else begin
                        dmem_e_s  = 1'b1;
                        dmem_we_s = 1'b1;
                    end
                end else if (ir[8]) begin
                    pc_e     = 1'b1;
                    mux1_sel = 1'b0;
                end else begin
                    pc_e     = 1'b1;
                    mux1_sel = 1'b1;
                end
            end
            default: begin
                pc_e = 1'b0;
            end
        endcase
    end

    assign a_s   = acc;
    assign b_s   = mux2_sel_s ? dr : ir[7:0];
    assign sh_s  = acc[2:0];
    assign asr_s = $signed(b_s) >>> sh_s;

    // ALU datapath: the 9-bit result carries C/borrow in bit 8; o_s is signed overflow.
    always_comb begin
        r9_s = 9'd0;
        o_s  = 1'b0;
        if (alu_e_s) begin
            case (alu_mode_s)
                4'h0: begin
                    r9_s = {1'b0, a_s} + {1'b0, b_s};
                    o_s  = (a_s[7] == b_s[7]) && (r9_s[7] != a_s[7]);
                end
                4'h1: begin
                    r9_s = {1'b0, a_s} - {1'b0, b_s};
                    o_s  = (a_s[7] != b_s[7]) && (r9_s[7] != a_s[7]);
                end
                4'h2: r9_s = {1'b0, a_s};
                4'h3: r9_s = {1'b0, b_s};
                4'h4: r9_s = {1'b0, a_s & b_s};
                4'h5: r9_s = {1'b0, a_s | b_s};
                4'h6: r9_s = {1'b0, a_s ^ b_s};
                4'h7: begin
                    r9_s = {1'b0, b_s} - {1'b0, a_s};
                    o_s  = (b_s[7] != a_s[7]) && (r9_s[7] != b_s[7]);
                end
                4'h8: begin
                    r9_s = {1'b0, b_s} + 9'd1;
                    o_s  = ~b_s[7] & r9_s[7];
                end
                4'h9: begin
                    r9_s = {1'b0, b_s} - 9'd1;
                    o_s  = b_s[7] & ~r9_s[7];
                end
`ifdef ALU_ROTATE_EN
                4'hA: r9_s = {1'b0, rotl8(b_s, sh_s)};
                4'hB: r9_s = {1'b0, rotr8(b_s, sh_s)};
`else
                4'hA: r9_s = {1'b0, b_s};
                4'hB: r9_s = {1'b0, b_s};
`endif
                4'hC: r9_s = {1'b0, b_s << sh_s};
                4'hD: r9_s = {1'b0, b_s >> sh_s};
                4'hE: r9_s = {1'b0, asr_s};
                4'hF: begin
                    // Negation overflows only for 0x80.
                    r9_s = 9'd0 - {1'b0, b_s};
                    o_s  = b_s[7] & r9_s[7];
                end
                default: r9_s = 9'd0;
            endcase
        end else begin
            r9_s = 9'd0;
            o_s  = 1'b0;
        end
    end

    // Result and flag outputs; flags pass through when the ALU is idle.
    always_comb begin
        alu_out = r9_s[7:0];
        if (alu_e_s) begin
            sr_new = {(r9_s[7:0] == 8'h00), r9_s[8], r9_s[7], o_s};
        end else begin
            sr_new = sr;
        end
    end

    assign addr_s     = ir[3:0];
    assign in_range_s = (32'(addr_s) < 32'(DMEM_WORDS));

    // Asynchronous data-memory read; out-of-range words read as zero.
    always_comb begin
        if (dmem_e_s && in_range_s) begin
            dmem_rdata = mem_q[addr_s];
        end else begin
            dmem_rdata = 8'h00;
        end
    end

    // Next memory contents: the ALU result lands in the addressed word on a store.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (dmem_e_s && dmem_we_s && in_range_s) begin
            mem_d[addr_s] = alu_out;
        end else begin
            mem_d[addr_s] = mem_q[addr_s];
        end
    end

    // Memory storage; reset clears every word and overrides a same-cycle store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mcu_exec_core.sv
// Testbench for mcu_exec_core: scoreboard of expected output vectors
// {alu_out, sr_new, dmem_rdata, pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e,
// pmem_le, mux1_sel}. Inputs change on the falling edge and are sampled
// 2 ns later, so any store takes effect at the rising edge that follows.
module tb_mcu_exec_core;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] FE = 2'b01;
    localparam logic [1:0] DE = 2'b10;
    localparam logic [1:0] EX = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stage;
    logic [11:0] ir;
    logic [3:0]  sr;
    logic [7:0]  acc;
    logic [7:0]  dr;
    logic [7:0]  alu_out;
    logic [3:0]  sr_new;
    logic [7:0]  dmem_rdata;
    logic        pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, mux1_sel;
    logic [27:0] obs;

    typedef struct {
        logic [27:0] v;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       ex;
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] mem_m [16];

    always #5 clk = ~clk;

    mcu_exec_core dut (
        .clk(clk), .rst(rst), .stage(stage), .ir(ir), .sr(sr), .acc(acc), .dr(dr),
        .alu_out(alu_out), .sr_new(sr_new), .dmem_rdata(dmem_rdata),
        .pc_e(pc_e), .acc_e(acc_e), .sr_e(sr_e), .ir_e(ir_e), .dr_e(dr_e),
        .pmem_e(pmem_e), .pmem_le(pmem_le), .mux1_sel(mux1_sel)
    );

    assign obs = {alu_out, sr_new, dmem_rdata, pc_e, acc_e, sr_e, ir_e, dr_e,
                  pmem_e, pmem_le, mux1_sel};

    function automatic logic [27:0] mk(input logic [7:0] a, input logic [3:0] f,
                                       input logic [7:0] rd, input logic [7:0] en);
        return {a, f, rd, en};
    endfunction

    // Independent ALU reference using integer arithmetic.
    function automatic void ref_alu(input logic [3:0] m, input logic [7:0] a,
                                    input logic [7:0] b, output logic [7:0] r,
                                    output logic [3:0] f);
        int ia, ib, sa, sbv, t, st, s;
        logic arith;
        logic [7:0] x;
        ia = int'(a);
        ib = int'(b);
        sa = $signed(a);
        sbv = $signed(b);
        s = ia % 8;
        arith = 1'b1;
        t = 0;
        st = 0;
        x = b;
        case (m)
            4'h0: begin t = ia + ib; st = sa + sbv; end
            4'h1: begin t = ia - ib; st = sa - sbv; end
            4'h7: begin t = ib - ia; st = sbv - sa; end
            4'h8: begin t = ib + 1; st = sbv + 1; end
            4'h9: begin t = ib - 1; st = sbv - 1; end
            4'hF: begin t = 0 - ib; st = 0 - sbv; end
            default: begin
                arith = 1'b0;
                case (m)
                    4'h2: t = ia;
                    4'h3: t = ib;
                    4'h4: t = ia & ib;
                    4'h5: t = ia | ib;
                    4'h6: t = ia ^ ib;
`ifdef ALU_ROTATE_EN
                    4'hA: begin
                        for (int k = 0; k < s; k++) x = {x[6:0], x[7]};
                        t = int'(x);
                    end
                    4'hB: begin
                        for (int k = 0; k < s; k++) x = {x[0], x[7:1]};
                        t = int'(x);
                    end
`else
                    4'hA: t = ib;
                    4'hB: t = ib;
`endif
                    4'hC: t = (ib << s) & 255;
                    4'hD: t = ib >> s;
                    4'hE: t = (sbv >>> s) & 255;
                    default: t = 0;
                endcase
            end
        endcase
        r = t[7:0];
        f = {(r == 8'h00), arith && (t < 0 || t > 255), r[7],
             arith && (st < -128 || st > 127)};
    endfunction

    task automatic step(input logic r, input logic [1:0] st, input logic [11:0] i,
                        input logic [3:0] s, input logic [7:0] a, input logic [7:0] d,
                        input logic [27:0] e, input string n);
        exp_t x;
        @(negedge clk);
        rst = r; stage = st; ir = i; sr = s; acc = a; dr = d;
        x.v = e;
        x.name = n;
        sb_q.push_back(x);
    endtask

    task automatic test_reset();
        step(1'b0, LD, 12'h000, 4'h0, 8'h00, 8'h00, mk(8'h00, 4'h0, 8'h00, 8'b00000110), "rst_load");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        step(1'b1, EX, 12'h225, 4'h0, 8'hA5, 8'h00, mk(8'hA5, 4'b0010, 8'h00, 8'b10100001), "rst_store");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        step(1'b1, DE, 12'h305, 4'h0, 8'h00, 8'h00, mk(8'h00, 4'h0, 8'hA5, 8'b00001000), "rst_readback");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        // Store while reset is low: the store must be dropped and the word cleared.
        step(1'b0, EX, 12'h225, 4'h0, 8'h3C, 8'h00, mk(8'h3C, 4'b0000, 8'hA5, 8'b10100001), "rst_store_in_reset");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        step(1'b1, DE, 12'h305, 4'h0, 8'h00, 8'h00, mk(8'h00, 4'h0, 8'h00, 8'b00001000), "rst_cleared");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    endtask

    task automatic test_stages();
        logic [11:0] irs [4] = '{12'h000, 12'h000, 12'h805, 12'h4A3};
        logic [1:0]  sts [4] = '{LD, FE, DE, DE};
        logic [3:0]  srs [4] = '{4'h0, 4'h0, 4'b1010, 4'b0101};
        logic [7:0]  ens [4] = '{8'b00000110, 8'b00010100, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sts[i], irs[i], srs[i], 8'h77, 8'h99, mk(8'h00, srs[i], 8'h00, ens[i]), "stage_enables");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
        end
    endtask

    task automatic test_alu_plan();
        logic [11:0] irs [6] = '{12'h805, 12'h801, 12'h380, 12'h3F0, 12'h310, 12'h3A0};
        logic [7:0]  as  [6] = '{8'hFB, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h01};
        logic [7:0]  ds  [6] = '{8'h00, 8'h00, 8'h7F, 8'h80, 8'h01, 8'h81};
`ifdef ALU_ROTATE_EN
        logic [7:0]  rs  [6] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h03};
        logic [3:0]  fs  [6] = '{4'b1100, 4'b0011, 4'b0011, 4'b0111, 4'b0110, 4'b0000};
`else
        logic [7:0]  rs  [6] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h81};
        logic [3:0]  fs  [6] = '{4'b1100, 4'b0011, 4'b0011, 4'b0111, 4'b0110, 4'b0010};
`endif
        for (int i = 0; i < 6; i++) begin
            step(1'b1, EX, irs[i], 4'h0, as[i], ds[i], mk(rs[i], fs[i], 8'h00, 8'b11100001), "alu_plan");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
        end
    endtask

    task automatic test_jumps();
        logic [11:0] irs [4] = '{12'h720, 12'h720, 12'h140, 12'h000};
        logic [3:0]  srs [4] = '{4'b1000, 4'b0000, 4'b1111, 4'b0000};
        logic        mx  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  s;
        logic [1:0]  k2;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, EX, irs[i], srs[i], 8'h12, 8'h34, mk(8'h00, srs[i], 8'h00, {7'b1000000, mx[i]}), "jump_plan");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
        end
        // Every flag index with random flags: jump taken exactly when the flag is set.
        for (int i = 0; i < 8; i++) begin
            k2 = 2'(i % 4);
            s = 4'($urandom_range(0, 15));
            step(1'b1, EX, {2'b01, k2, 8'h55}, s, 8'h00, 8'h00, mk(8'h00, s, 8'h00, {7'b1000000, ~s[k2]}), "jump_flag");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
        end
    endtask

    task automatic test_alu_sweep();
        logic [7:0] a, b, r;
        logic [3:0] f, m;
        for (int i = 0; i < 24; i++) begin
            m = 4'(i % 8);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            ref_alu(m, a, b, r, f);
            step(1'b1, EX, {1'b1, m[2:0], b}, 4'($urandom_range(0, 15)), a, 8'h00, mk(r, f, 8'h00, 8'b11100001), "alu_itype");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[mode %0h]: got %h want %h", ex.name, m, obs, ex.v); end
        end
        for (int i = 0; i < 48; i++) begin
            m = 4'(i % 16);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            ref_alu(m, a, b, r, f);
            step(1'b1, EX, {4'b0011, m, 4'h0}, 4'($urandom_range(0, 15)), a, b, mk(r, f, 8'h00, 8'b11100001), "alu_mtype");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[mode %0h]: got %h want %h", ex.name, m, obs, ex.v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [3:0] ad;
        step(1'b1, EX, 12'h223, 4'h0, 8'h5A, 8'h11, mk(8'h5A, 4'b0000, 8'h00, 8'b10100001), "store_5a");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        mem_m[3] = 8'h5A;
        step(1'b1, DE, 12'h303, 4'h0, 8'h00, 8'h00, mk(8'h00, 4'h0, 8'h5A, 8'b00001000), "load_5a");
        #2; ex = sb_q.pop_front(); cmp_cnt++;
        if (obs !== ex.v) begin err_cnt++; $display("FAIL %s: got %h want %h", ex.name, obs, ex.v); end
        // Consecutive stores (mode 3 = B = dr); read data shows the pre-write word.
        for (int i = 0; i < 16; i++) begin
            ad = 4'(i);
            v = 8'($urandom_range(0, 255));
            step(1'b1, EX, {4'b0010, 4'h3, ad}, 4'h0, 8'hC3, v,
                 mk(v, {(v == 8'h00), 1'b0, v[7], 1'b0}, mem_m[ad], 8'b10100001), "store_seq");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
            mem_m[ad] = v;
        end
        for (int i = 15; i >= 0; i--) begin
            ad = 4'(i);
            step(1'b1, DE, {4'b0011, 4'h0, ad}, 4'b0110, 8'h00, 8'h00, mk(8'h00, 4'b0110, mem_m[ad], 8'b00001000), "load_seq");
            #2; ex = sb_q.pop_front(); cmp_cnt++;
            if (obs !== ex.v) begin err_cnt++; $display("FAIL %s[%0d]: got %h want %h", ex.name, i, obs, ex.v); end
        end
    endtask

    initial begin
        rst = 1'b0; stage = LD; ir = 12'h000; sr = 4'h0; acc = 8'h00; dr = 8'h00;
        test_reset();
        test_stages();
        test_alu_plan();
        test_jumps();
        test_alu_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
